// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one instruction-memory request at a time,
// waits for the in-order response, and holds the fetched instruction for
// decode. A flush redirects the PC and discards any fetch still in flight.
// Misaligned PCs and memory timeouts park the stage in a sticky error state
// that only reset clears.
module instr_fetch #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_write,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_err,
  output logic [1:0]  err_code
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  localparam logic [1:0] ERR_MISALIGNED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT    = 2'b10;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [2:0]  r_state;
  logic        r_discard;
  logic [7:0]  r_count;
  logic [31:0] r_reqPc;
  logic [31:0] r_idInstr;
  logic [31:0] r_idPc;
  logic [31:0] r_idPcPlus4;
  logic        r_err;
  logic [1:0]  r_errCode;

  logic        w_misaligned;
  logic        w_reqValid;
  logic        w_handshake;
  logic        w_capture;
  logic        w_pcWriteAllowed;
  logic [7:0]  w_countNext;

  // A misaligned PC suppresses the request unless a flush is redirecting it
  // this very cycle, in which case the outgoing request is discarded anyway.
  assign w_misaligned     = (pc[1:0] != 2'b00);
  assign w_reqValid       = (r_state == REQ) && !(w_misaligned && !flush);
  assign w_handshake      = w_reqValid && imem_req_ready;
  assign w_capture        = (r_state == WAIT) && imem_rsp_valid && !r_discard && !flush;
  assign w_pcWriteAllowed = (r_state != ERR) && (r_state != IDLE);
  assign w_countNext      = r_count + 8'd1;

  // The PC register advances on a good capture or loads the branch target on
  // a flush; when both coincide the flush wins and it is still one pulse.
  assign pc_write       = w_pcWriteAllowed && (w_capture || flush);
  assign imem_req_valid = w_reqValid;
  assign imem_addr      = w_reqValid ? pc : 32'd0;
  assign id_valid       = (r_state == HOLD);
  assign id_instr       = r_idInstr;
  assign id_pc          = r_idPc;
  assign id_pc_plus4    = r_idPcPlus4;
  assign fetch_err      = r_err;
  assign err_code       = r_errCode;

  // Fetch control FSM: request issue, response wait with discard/timeout,
  // decode hand-off and the terminal error state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_discard <= 1'b0;
      r_count   <= 8'd0;
      r_reqPc   <= 32'd0;
      r_err     <= 1'b0;
      r_errCode <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= REQ;
        end
        REQ: begin
          if (w_misaligned && !flush) begin
            r_state   <= ERR;
            r_err     <= 1'b1;
            r_errCode <= ERR_MISALIGNED;
          end else if (w_handshake) begin
            r_reqPc   <= pc;
            r_count   <= 8'd0;
            r_discard <= flush;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            r_discard <= 1'b0;
            r_state   <= w_capture ? HOLD : REQ;
          end else begin
            if (flush) begin
              r_discard <= 1'b1;
            end
            r_count <= w_countNext;
            if (w_countNext == TIMEOUT_CNT) begin
              r_state   <= ERR;
              r_err     <= 1'b1;
              r_errCode <= ERR_TIMEOUT;
            end
          end
        end
        HOLD: begin
          if (flush || id_ready) begin
            r_state <= REQ;
          end
        end
        ERR: begin
          r_state <= ERR;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Decode-stage registers load only on a good capture and stay frozen while
  // the instruction waits in HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idInstr   <= 32'd0;
      r_idPc      <= 32'd0;
      r_idPcPlus4 <= 32'd0;
    end else if (w_capture) begin
      r_idInstr   <= imem_rsp_data;
      r_idPc      <= r_reqPc;
      r_idPcPlus4 <= r_reqPc + 32'd4;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: models the PC register and an
// in-order instruction memory, and scoreboards every fetch handed to decode.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        pc_write;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_err;
  logic [1:0]  err_code;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } sbEntry_t;

  sbEntry_t    sbQ[$];
  int          vectorsApplied = 0;
  int          miscompares    = 0;
  int          pwCount        = 0;
  int          reqCount       = 0;
  int          deliveredCount = 0;
  int          memLatency     = 1;
  int          pendCnt        = 0;
  logic [31:0] pendData       = 32'd0;
  logic [31:0] flushTarget    = 32'd0;

  instr_fetch #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .pc_write       (pc_write),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .fetch_err      (fetch_err),
    .err_code       (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] memData(input logic [31:0] a);
    case (a)
      32'h0040_0000: return 32'h8C08_0004;
      32'h0040_0010: return 32'hDEAD_BEEF;
      default:       return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock: sample what the DUT sees at the coming edge, then update the
  // PC register and memory models and let combinational outputs settle.
  task automatic applyStimulus();
    logic        rs, hs, pw, fl, acc;
    logic [31:0] addr;
    sbEntry_t    e;
    @(negedge clk);
    rs   = reset;
    hs   = imem_req_valid & imem_req_ready;
    addr = imem_addr;
    pw   = pc_write;
    fl   = flush;
    acc  = id_valid & id_ready;
    if (rs !== 1'b1) begin
      if (pw === 1'b1) pwCount++;
      if (hs === 1'b1) reqCount++;
      if (acc === 1'b1 && fl !== 1'b1) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedIssue", 32'd1, 32'd0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("sbInstr", id_instr, e.instr);
          checkOutput("sbPc", id_pc, e.pc);
          checkOutput("sbPcPlus4", id_pc_plus4, e.pc4);
          deliveredCount++;
        end
      end
      if (fl === 1'b1) sbQ.delete();
      if (hs === 1'b1 && fl !== 1'b1) sbQ.push_back('{memData(addr), addr, addr + 32'd4});
    end else begin
      sbQ.delete();
    end
    @(posedge clk);
    #1;
    if (rs !== 1'b1 && pw === 1'b1) pc = (fl === 1'b1) ? flushTarget : pc + 32'd4;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    if (hs === 1'b1 && memLatency > 0) begin
      pendCnt  = memLatency;
      pendData = memData(addr);
    end
    if (pendCnt > 0) begin
      pendCnt--;
      if (pendCnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pendData;
      end
    end
    #1;
  endtask

  task automatic runFetch(input string tag);
    int start;
    start = deliveredCount;
    for (int i = 0; i < 30; i++) begin
      applyStimulus();
      if (deliveredCount != start) break;
    end
    checkOutput({tag, "Delivered"}, 32'(deliveredCount - start), 32'd1);
  endtask

  task automatic waitIdValid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      if (id_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, "IdValidSeen"}, 32'(seen), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "PcWrite"}, 32'(pc_write), 32'd0);
    checkOutput({tag, "ReqValid"}, 32'(imem_req_valid), 32'd0);
    checkOutput({tag, "Addr"}, imem_addr, 32'd0);
    checkOutput({tag, "IdValid"}, 32'(id_valid), 32'd0);
    checkOutput({tag, "IdInstr"}, id_instr, 32'd0);
    checkOutput({tag, "IdPc"}, id_pc, 32'd0);
    checkOutput({tag, "IdPc4"}, id_pc_plus4, 32'd0);
    checkOutput({tag, "FetchErr"}, 32'(fetch_err), 32'd0);
    checkOutput({tag, "ErrCode"}, 32'(err_code), 32'd0);
  endtask

  // Hard stop in case a wait loop is broken in a way the bounds miss.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pw0;
    int req0;
    int n;
    sbEntry_t e;

    reset          = 1'b1;
    pc             = 32'h0040_0000;
    flush          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    id_ready       = 1'b1;

    // Reset state.
    applyStimulus();
    applyStimulus();
    checkAllZero("reset");

    // Basic fetch with one-cycle memory latency.
    reset = 1'b0;
    pw0 = pwCount;
    applyStimulus();
    checkOutput("basicReqValid", 32'(imem_req_valid), 32'd1);
    checkOutput("basicAddr", imem_addr, 32'h0040_0000);
    applyStimulus();
    checkOutput("basicPcWrite", 32'(pc_write), 32'd1);
    applyStimulus();
    checkOutput("basicIdValid", 32'(id_valid), 32'd1);
    checkOutput("basicIdInstr", id_instr, 32'h8C08_0004);
    checkOutput("basicIdPc", id_pc, 32'h0040_0000);
    checkOutput("basicIdPc4", id_pc_plus4, 32'h0040_0004);
    checkOutput("basicPcWriteNow", 32'(pc_write), 32'd0);
    applyStimulus();
    checkOutput("basicNextReq", 32'(imem_req_valid), 32'd1);
    checkOutput("basicNextAddr", imem_addr, 32'h0040_0004);
    checkOutput("basicIdValidDrop", 32'(id_valid), 32'd0);
    checkOutput("basicPcWriteCount", 32'(pwCount - pw0), 32'd1);

    // Back-to-back fetches with varying memory latency.
    for (int k = 0; k < 4; k++) begin
      memLatency = 1 + (k % 3);
      runFetch("seq");
    end
    memLatency = 1;

    // Decode stall in HOLD.
    id_ready = 1'b0;
    waitIdValid("hold");
    checkOutput("holdSbSize", 32'(sbQ.size()), 32'd1);
    if (sbQ.size() > 0) begin
      e    = sbQ[0];
      req0 = reqCount;
      for (int i = 0; i < 5; i++) begin
        applyStimulus();
        checkOutput("holdIdValid", 32'(id_valid), 32'd1);
        checkOutput("holdIdInstr", id_instr, e.instr);
        checkOutput("holdIdPc", id_pc, e.pc);
        checkOutput("holdNoReq", 32'(imem_req_valid), 32'd0);
      end
      checkOutput("holdReqCount", 32'(reqCount - req0), 32'd0);
      id_ready = 1'b1;
      applyStimulus();
      checkOutput("holdReleaseReq", 32'(imem_req_valid), 32'd1);
    end

    // Flush during WAIT: stale response must be dropped.
    memLatency  = 3;
    pc          = 32'h0040_0010;
    flushTarget = 32'h0040_1000;
    pw0 = pwCount;
    #1;
    applyStimulus();
    flush = 1'b1;
    #1;
    checkOutput("flushWaitPcWrite", 32'(pc_write), 32'd1);
    applyStimulus();
    flush = 1'b0;
    #1;
    checkOutput("flushWaitPcWrite2", 32'(pc_write), 32'd0);
    applyStimulus();
    checkOutput("flushWaitStaleIdValid", 32'(id_valid), 32'd0);
    checkOutput("flushWaitStalePcWrite", 32'(pc_write), 32'd0);
    applyStimulus();
    checkOutput("flushWaitIdValid", 32'(id_valid), 32'd0);
    checkOutput("flushWaitNewReq", 32'(imem_req_valid), 32'd1);
    checkOutput("flushWaitNewAddr", imem_addr, 32'h0040_1000);
    checkOutput("flushWaitPwCount", 32'(pwCount - pw0), 32'd1);
    runFetch("flushWaitAfter");
    memLatency = 1;

    // Flush in REQ without a handshake: request moves to the new PC.
    imem_req_ready = 1'b0;
    flushTarget    = 32'h0040_2000;
    flush          = 1'b1;
    #1;
    checkOutput("flushReqPcWrite", 32'(pc_write), 32'd1);
    applyStimulus();
    flush = 1'b0;
    #1;
    checkOutput("flushReqValid", 32'(imem_req_valid), 32'd1);
    checkOutput("flushReqAddr", imem_addr, 32'h0040_2000);
    applyStimulus();
    checkOutput("flushReqAddrStable", imem_addr, 32'h0040_2000);
    imem_req_ready = 1'b1;
    runFetch("flushReq");

    // Flush in REQ coinciding with a handshake: that fetch is discarded.
    flushTarget = 32'h0040_3000;
    flush       = 1'b1;
    applyStimulus();
    flush = 1'b0;
    #1;
    checkOutput("flushHsDropPcWrite", 32'(pc_write), 32'd0);
    applyStimulus();
    checkOutput("flushHsIdValid", 32'(id_valid), 32'd0);
    checkOutput("flushHsReq", 32'(imem_req_valid), 32'd1);
    checkOutput("flushHsAddr", imem_addr, 32'h0040_3000);
    runFetch("flushHs");

    // Flush while holding an instruction for decode.
    id_ready = 1'b0;
    waitIdValid("flushHold");
    flushTarget = 32'h0040_4000;
    flush       = 1'b1;
    applyStimulus();
    flush = 1'b0;
    #1;
    checkOutput("flushHoldIdValid", 32'(id_valid), 32'd0);
    checkOutput("flushHoldReq", 32'(imem_req_valid), 32'd1);
    checkOutput("flushHoldAddr", imem_addr, 32'h0040_4000);
    id_ready = 1'b1;
    runFetch("flushHoldAfter");

    // PC+4 wraps at the top of the address space.
    pc       = 32'hFFFF_FFFC;
    id_ready = 1'b0;
    #1;
    waitIdValid("wrap");
    checkOutput("wrapIdPc", id_pc, 32'hFFFF_FFFC);
    checkOutput("wrapIdPc4", id_pc_plus4, 32'h0000_0000);
    id_ready = 1'b1;
    applyStimulus();

    // Reset in the middle of WAIT: the late response must be ignored.
    reset      = 1'b1;
    memLatency = 3;
    pc         = 32'h0040_0020;
    applyStimulus();
    reset = 1'b0;
    applyStimulus();
    applyStimulus();
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    applyStimulus();
    reset = 1'b0;
    applyStimulus();
    checkOutput("lateRspIdValid", 32'(id_valid), 32'd0);
    checkOutput("lateRspReq", 32'(imem_req_valid), 32'd1);
    checkOutput("lateRspPcWrite", 32'(pc_write), 32'd0);
    applyStimulus();
    checkOutput("lateRspIdValid2", 32'(id_valid), 32'd0);
    checkOutput("lateRspAddr", imem_addr, 32'h0040_0020);
    memLatency     = 1;
    imem_req_ready = 1'b1;
    runFetch("lateRspAfter");

    // Timeout: no response ever arrives.
    memLatency = 0;
    pw0 = pwCount;
    applyStimulus();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      n++;
      if (fetch_err === 1'b1) break;
    end
    checkOutput("timeoutCycles", 32'(n), 32'd4);
    checkOutput("timeoutErrCode", 32'(err_code), 32'd2);
    checkOutput("timeoutPwCount", 32'(pwCount - pw0), 32'd0);
    checkOutput("timeoutReqValid", 32'(imem_req_valid), 32'd0);
    memLatency = 1;

    // Misaligned PC: sticky error that ignores flushes and responses.
    reset = 1'b1;
    applyStimulus();
    pc    = 32'h0040_0002;
    reset = 1'b0;
    applyStimulus();
    checkOutput("misReqValid", 32'(imem_req_valid), 32'd0);
    checkOutput("misErrEarly", 32'(fetch_err), 32'd0);
    applyStimulus();
    checkOutput("misFetchErr", 32'(fetch_err), 32'd1);
    checkOutput("misErrCode", 32'(err_code), 32'd1);
    for (int i = 0; i < 4; i++) begin
      flush          = (i % 2 == 0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h1234_5678;
      #1;
      checkOutput("errPcWrite", 32'(pc_write), 32'd0);
      checkOutput("errReqValid", 32'(imem_req_valid), 32'd0);
      applyStimulus();
      checkOutput("errFetchErr", 32'(fetch_err), 32'd1);
      checkOutput("errErrCode", 32'(err_code), 32'd1);
      checkOutput("errIdValid", 32'(id_valid), 32'd0);
    end
    flush = 1'b0;
    reset = 1'b1;
    applyStimulus();
    checkAllZero("errReset");

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
